mult_arbiter: RTL and testbench



---
 rtl/mult_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/mult_arbiter.sv | 137 +++++++++++++
 tb/tb_mult_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared types and constants for the multiplier arbiter slice.
//   state_t      FSM encoding used by mult_arbiter (IDLE, EXEC, RESP)
//   OP_W/PROD_W  operand and product widths of the shared multiplier
//   DEF_N        default requester count
//   DEF_MUL_LAT  default number of cycles operands are held before sampling
package mult_arb_pkg;

  localparam int OP_W        = 8;
  localparam int PROD_W      = 16;
  localparam int DEF_N       = 4;
  localparam int DEF_MUL_LAT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req   in  N    request vector
//   ptr   in  IDW  index of the last winner; the search starts at ptr+1
//   grant out N    one-hot winner, all zero when no request is present
//   idx   out IDW  binary index of the winner (0 when no request)
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx
);

  logic           found;
  logic [IDW-1:0] cand;
  int             pos;

  // Walk ptr+1, ptr+2, ... wrapping at N; the last winner is visited last.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    pos   = 0;
    for (int k = 1; k <= N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      cand = IDW'(pos);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one external 8x8 combinational multiplier among N
// requesters. A round-robin winner's operands are registered and driven onto
// the multiplier; the registers only change when a job is accepted, so the
// multiplier sees no toggling while idle. After MUL_LAT cycles the product is
// captured and returned with the owner's index under valid/ready backpressure.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   req_valid     N      per-requester job valid
//   req_a/req_b   N*8    per-requester operands, slice i = [8i+7:8i]
//   req_ready     N      one-hot accept, only in IDLE
//   mul_a/mul_b   8      operand registers to the shared multiplier
//   mul_p         16     product from the shared multiplier
//   rsp_valid     1      result valid
//   rsp_id        IDW    owner of the result
//   rsp_product   16     registered product
//   rsp_ready     1      downstream accepts the result
//   busy          1      high in EXEC or RESP
//
// Build option MULT_ARB_ZERO_BYPASS_EN: a job with a zero operand is answered
// with product 0 straight from IDLE, skipping EXEC and leaving the multiplier
// inputs untouched.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int IDW     = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req_valid,
  input  logic [N*OP_W-1:0]   req_a,
  input  logic [N*OP_W-1:0]   req_b,
  output logic [N-1:0]        req_ready,
  output logic [OP_W-1:0]     mul_a,
  output logic [OP_W-1:0]     mul_b,
  input  logic [PROD_W-1:0]   mul_p,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [PROD_W-1:0]   rsp_product,
  input  logic                rsp_ready,
  output logic                busy
);

  localparam int             LCW      = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [LCW-1:0] LAT_INIT = LCW'(MUL_LAT - 1);

  state_t            state;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic [IDW-1:0]    rr_ptr;
  logic [LCW-1:0]    lat_cnt;

  logic [N-1:0]      grant;
  logic [IDW-1:0]    gidx;
  logic [OP_W-1:0]   ga;
  logic [OP_W-1:0]   gb;
  logic              accept;
  logic              zero_job;

  rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx)
  );

  assign ga        = req_a[int'(gidx)*OP_W +: OP_W];
  assign gb        = req_b[int'(gidx)*OP_W +: OP_W];
  assign accept    = (state == IDLE) && (|req_valid);
  assign req_ready = (state == IDLE) ? grant : '0;
  assign mul_a     = op_a;
  assign mul_b     = op_b;
  assign busy      = (state != IDLE);

`ifdef MULT_ARB_ZERO_BYPASS_EN
  assign zero_job = (ga == '0) || (gb == '0);
`else
  assign zero_job = 1'b0;
`endif

  // Stage boundary: operand capture (IDLE) -> settle (EXEC) -> result (RESP)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      rr_ptr      <= IDW'(N - 1);
      lat_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_id <= gidx;
            rr_ptr <= gidx;
            if (zero_job) begin
              // Result is known to be zero; the op registers keep their
              // previous contents so the multiplier stays quiet.
              rsp_product <= '0;
              rsp_valid   <= 1'b1;
              state       <= RESP;
            end else begin
              op_a    <= ga;
              op_b    <= gb;
              lat_cnt <= LAT_INIT;
              state   <= EXEC;
            end
          end
        end
        EXEC: begin
          if (lat_cnt == '0) begin
            rsp_product <= mul_p;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            lat_cnt <= lat_cnt - LCW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed self-checking bench for mult_arbiter.
// u_dut (N=4, MUL_LAT=1) carries the main sequence; u_dut3 (MUL_LAT=3)
// covers the long-latency and reset-during-EXEC cases. The shared multiplier
// is modelled behaviourally for each instance.
module tb_mult_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*8-1:0] req_a, req_b;
  logic [N-1:0]  req_ready;
  logic [7:0]    mul_a, mul_b;
  logic [15:0]   mul_p;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [15:0]   rsp_product;
  logic          rsp_ready;
  logic          busy;

  // long-latency instance
  logic          rst3;
  logic [N-1:0]  req_valid3;
  logic [N*8-1:0] req_a3, req_b3;
  logic [N-1:0]  req_ready3;
  logic [7:0]    mul_a3, mul_b3;
  logic [15:0]   mul_p3;
  logic          rsp_valid3;
  logic [1:0]    rsp_id3;
  logic [15:0]   rsp_product3;
  logic          rsp_ready3;
  logic          busy3;

  assign mul_p  = 16'(mul_a)  * 16'(mul_b);
  assign mul_p3 = 16'(mul_a3) * 16'(mul_b3);

  mult_arbiter #(.N(N), .MUL_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  mult_arbiter #(.N(N), .MUL_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3),
    .req_ready(req_ready3), .mul_a(mul_a3), .mul_b(mul_b3), .mul_p(mul_p3),
    .rsp_valid(rsp_valid3), .rsp_id(rsp_id3), .rsp_product(rsp_product3),
    .rsp_ready(rsp_ready3), .busy(busy3)
  );

  typedef struct {
    int          id;
    logic [15:0] prod;
  } exp_t;

  exp_t sb[$];
  int   order[$];
  int   vectors = 0;
  int   errors  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: push at a visible grant, pop at a completed response.
  exp_t mon_e;
  int   mon_idx;
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      chk("sb_has_entry", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("sb_rsp_id", 32'(rsp_id), mon_e.id);
        chk("sb_rsp_product", 32'(rsp_product), 32'(mon_e.prod));
      end
    end
    if (|req_ready) begin
      chk("grant_onehot", 32'($onehot(req_ready)), 1);
      mon_idx = 0;
      for (int i = 0; i < N; i++) if (req_ready[i]) mon_idx = i;
      mon_e.id   = mon_idx;
      mon_e.prod = 16'(req_a[8*mon_idx +: 8]) * 16'(req_b[8*mon_idx +: 8]);
      sb.push_back(mon_e);
      order.push_back(mon_idx);
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accept edge.
  task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b);
    bit got;
    logic [N-1:0] oh;
    got = 1'b0;
    oh  = '0;
    oh[i] = 1'b1;
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req_valid[i]    = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("grant_seen", 32'(got), 1);
    chk("req_ready_onehot", 32'(req_ready), 32'(oh));
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (rsp_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk(tag, 32'(seen), 1);
  endtask

  initial begin
    bit idle;
    rst = 1'b1; rst3 = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    req_valid3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b1;
    @(posedge clk); #1;

    // reset state
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_mul_a", 32'(mul_a), 0);
    chk("rst_mul_b", 32'(mul_b), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_product", 32'(rsp_product), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    rst = 1'b0; rst3 = 1'b0;
    @(posedge clk); #1;

    // single job, 13*11
    issue(0, 8'd13, 8'd11);
    chk("t1_mul_a", 32'(mul_a), 13);
    chk("t1_mul_b", 32'(mul_b), 11);
    chk("t1_no_early_rsp", 32'(rsp_valid), 0);
    chk("t1_busy", 32'(busy), 1);
    @(posedge clk); #1;
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_product", 32'(rsp_product), 143);
    chk("t1_rsp_id", 32'(rsp_id), 0);
    @(posedge clk); #1;
    chk("t1_back_idle", 32'(busy), 0);

    // corner products
    issue(2, 8'd255, 8'd255);
    wait_rsp("t3_rsp_a");
    chk("t3_max_product", 32'(rsp_product), 65025);
    @(posedge clk); #1;
    issue(3, 8'd1, 8'd128);
    wait_rsp("t3_rsp_b");
    chk("t3_product_128", 32'(rsp_product), 128);
    @(posedge clk); #1;

    // backpressure in RESP
    rsp_ready = 1'b0;
    issue(1, 8'd7, 8'd9);
    wait_rsp("t4_rsp");
    req_a[16 +: 8] = 8'd5; req_b[16 +: 8] = 8'd6; req_valid[2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", 32'(rsp_valid), 1);
      chk("t4_hold_product", 32'(rsp_product), 63);
      chk("t4_hold_id", 32'(rsp_id), 1);
      chk("t4_no_grant", 32'(req_ready), 0);
      chk("t4_hold_mul_a", 32'(mul_a), 7);
      chk("t4_hold_mul_b", 32'(mul_b), 9);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_released_idle", 32'(busy), 0);
    chk("t4_next_grant", 32'(req_ready), 32'(4'b0100));
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    wait_rsp("t4_next_rsp");
    chk("t4_next_product", 32'(rsp_product), 30);
    @(posedge clk); #1;

    // zero operand
    issue(0, 8'd0, 8'd200);
`ifdef MULT_ARB_ZERO_BYPASS_EN
    chk("t6_bypass_valid", 32'(rsp_valid), 1);
    chk("t6_bypass_product", 32'(rsp_product), 0);
    chk("t6_bypass_mul_a", 32'(mul_a), 5);
    chk("t6_bypass_mul_b", 32'(mul_b), 6);
    @(posedge clk); #1;
`else
    chk("t6_exec_not_valid", 32'(rsp_valid), 0);
    chk("t6_mul_a", 32'(mul_a), 0);
    chk("t6_mul_b", 32'(mul_b), 200);
    @(posedge clk); #1;
    chk("t6_rsp_valid", 32'(rsp_valid), 1);
    chk("t6_rsp_product", 32'(rsp_product), 0);
    @(posedge clk); #1;
`endif

    // round-robin with all requesters busy, after a fresh reset
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    order.delete();
    req_a = {8'd255, 8'd200, 8'd100, 8'd13};
    req_b = {8'd2,   8'd3,   8'd7,   8'd11};
    req_valid = 4'hF;
    repeat (16) begin
      @(posedge clk); #1;
    end
    req_valid = '0;
    idle = 1'b0;
    for (int k = 0; k < 10 && !idle; k++) begin
      @(posedge clk); #1;
      if (!busy) idle = 1'b1;
    end
    chk("t2_drained", 32'(idle), 1);
    chk("t2_grant_count", 32'(order.size()), 6);
    for (int k = 0; k < 6 && k < order.size(); k++)
      chk("t2_grant_order", 32'(order[k]), 32'(k % 4));

    // long latency instance, then reset in the middle of EXEC
    req_a3 = {8'd0, 8'd0, 8'd6, 8'd9};
    req_b3 = {8'd0, 8'd0, 8'd7, 8'd9};
    req_valid3 = 4'b0001;
    @(negedge clk);
    chk("t5_first_grant", 32'(req_ready3), 1);
    @(posedge clk); #1;
    req_valid3 = '0;
    chk("t5_busy", 32'(busy3), 1);
    chk("t5_mul_a", 32'(mul_a3), 9);
    repeat (2) begin
      @(posedge clk); #1;
      chk("t5_settling", 32'(rsp_valid3), 0);
    end
    @(posedge clk); #1;
    chk("t5_lat3_valid", 32'(rsp_valid3), 1);
    chk("t5_lat3_product", 32'(rsp_product3), 81);
    @(posedge clk); #1;
    req_valid3 = 4'b0010;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid3 = '0;
    chk("t5_in_exec", 32'(busy3), 1);
    @(posedge clk); #1;
    #2 rst3 = 1'b1;
    #1;
    chk("t5_arst_rsp_valid", 32'(rsp_valid3), 0);
    chk("t5_arst_mul_a", 32'(mul_a3), 0);
    chk("t5_arst_mul_b", 32'(mul_b3), 0);
    chk("t5_arst_busy", 32'(busy3), 0);
    req_valid3 = 4'b1010;
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(negedge clk);
    chk("t5_grant_after_reset", 32'(req_ready3), 32'(4'b0010));
    @(posedge clk); #1;
    req_valid3 = '0;

    chk("sb_empty_at_end", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
